// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall sequencer: merges load-use stalls with multi-cycle execute occupancy.
// Optional stall-cycle performance counter built only when PIPE_STALL_PERF_EN is defined.
module pipe_stall_ctrl #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             stallreq_id_i,
    input  logic             mc_start_i,
    input  logic [CNT_W-1:0] mc_len_i,
    output logic [5:0]       stall_o,
    output logic             mc_done_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] mc_cnt_o,
    output logic [31:0]      perf_stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_MC   = 6'b001111;
    localparam logic [5:0] STALL_LU   = 6'b000111;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A zero length is treated as one cycle, so the counter loads L-1 clamped at 0.
    assign accept = rst && (state == IDLE) && mc_start_i && !flush_i;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt = BUSY;
                        cnt_nxt   = (mc_len_i == '0) ? '0 : mc_len_i - CNT_W'(1);
                    end
                end
                BUSY: begin
                    if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
                    else           state_nxt = DONE;
                end
                DONE:    state_nxt = IDLE;
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs stay quiet while reset is held, even if inputs toggle.
    always_comb begin
        stall_o   = STALL_NONE;
        mc_done_o = 1'b0;
        if (rst && !flush_i) begin
            if ((state == BUSY) || accept) stall_o = STALL_MC;
            else if (stallreq_id_i)        stall_o = STALL_LU;
            mc_done_o = (state == DONE);
        end
    end

    assign busy_o   = (state == BUSY);
    assign mc_cnt_o = cnt;

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cnt <= '0;
        end else if (stall_o[0] && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_cnt;
`else
    assign perf_stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed plus randomized bench for pipe_stall_ctrl against a timeline-based reference model.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        stallreq_id_i;
    logic        mc_start_i;
    logic [5:0]  mc_len_i;
    logic [5:0]  stall_o;
    logic        mc_done_o;
    logic        busy_o;
    logic [5:0]  mc_cnt_o;
    logic [31:0] perf_stall_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference: an accepted op of length L occupies k = 1..L+1 cycles after acceptance.
    bit          op_active = 1'b0;
    int          op_k      = 0;
    int          op_len    = 0;
    longint      perf_exp  = 0;

    pipe_stall_ctrl #(.CNT_W(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .stallreq_id_i    (stallreq_id_i),
        .mc_start_i       (mc_start_i),
        .mc_len_i         (mc_len_i),
        .stall_o          (stall_o),
        .mc_done_o        (mc_done_o),
        .busy_o           (busy_o),
        .mc_cnt_o         (mc_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] perf_model();
`ifdef PIPE_STALL_PERF_EN
        return perf_exp[31:0];
`else
        return 32'h0;
`endif
    endfunction

    // Drive one cycle of inputs, check combinational and registered outputs, advance model.
    task automatic cycle(input bit f, input bit sr, input bit st, input int len);
        bit       busy_e, done_e, acc_e;
        int       cnt_e;
        logic [5:0] stall_e;
        flush_i       = f;
        stallreq_id_i = sr;
        mc_start_i    = st;
        mc_len_i      = 6'(len);
        #1;
        busy_e  = op_active && (op_k <= op_len);
        done_e  = op_active && (op_k == op_len + 1) && !f;
        cnt_e   = busy_e ? (op_len - op_k) : 0;
        acc_e   = !op_active && st && !f;
        if (f)                    stall_e = 6'b000000;
        else if (busy_e || acc_e) stall_e = 6'b001111;
        else if (sr)              stall_e = 6'b000111;
        else                      stall_e = 6'b000000;
        chk("stall", 32'(stall_o), 32'(stall_e));
        chk("done",  32'(mc_done_o), 32'(done_e));
        chk("busy",  32'(busy_o), 32'(busy_e));
        chk("cnt",   32'(mc_cnt_o), 32'(cnt_e));
        chk("perf",  perf_stall_cnt_o, perf_model());
        @(posedge clk);
        if (stall_e[0] && perf_exp < 64'hFFFF_FFFF) perf_exp++;
        if (f) begin
            op_active = 1'b0;
        end else if (acc_e) begin
            op_active = 1'b1;
            op_k      = 1;
            op_len    = (len == 0) ? 1 : len;
        end else if (op_active) begin
            if (op_k == op_len + 1) op_active = 1'b0;
            else                    op_k++;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        #1;
        chk({tag, "_stall"}, 32'(stall_o), 32'h0);
        chk({tag, "_done"},  32'(mc_done_o), 32'h0);
        chk({tag, "_busy"},  32'(busy_o), 32'h0);
        chk({tag, "_cnt"},   32'(mc_cnt_o), 32'h0);
        chk({tag, "_perf"},  perf_stall_cnt_o, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush_i = 1'b0; stallreq_id_i = 1'b0; mc_start_i = 1'b0; mc_len_i = '0;
        op_active = 1'b0;
        perf_exp  = 0;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        flush_i = 1'b0; stallreq_id_i = 1'b0; mc_start_i = 1'b0; mc_len_i = '0;
        @(negedge clk);
        do_reset();

        // Idle with all inputs low.
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);

        // L=4 operation: 5 stall cycles, counter 3..0, done in T+5.
        cycle(0, 0, 1, 4);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        // Two load-use cycles while idle.
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
`ifdef PIPE_STALL_PERF_EN
        chk("perf_after_l4_lu2", perf_stall_cnt_o, 32'd7);
`else
        chk("perf_tied_zero", perf_stall_cnt_o, 32'd0);
`endif
        cycle(0, 0, 0, 0);

        // Zero length behaves as L=1.
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

        // Load-use during BUSY is absorbed; start during DONE is ignored.
        cycle(0, 0, 1, 3);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 9);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 5);
        cycle(0, 0, 0, 0);

        // L=10 flushed in its 4th BUSY cycle, then an immediate restart.
        cycle(0, 0, 1, 10);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(1, 1, 1, 7);
        cycle(0, 0, 1, 2);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

        // Flush landing on the done cycle suppresses the strobe.
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Asynchronous reset mid-operation.
        cycle(0, 0, 1, 8);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        #2;
        rst = 1'b0;
        op_active = 1'b0;
        perf_exp  = 0;
        check_reset_outputs("midop");
        @(negedge clk);
        check_reset_outputs("midop_held");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

`ifdef PIPE_STALL_PERF_EN
        // Saturation near the top of the counter.
        dut.perf_cnt = 32'hFFFF_FFFE;
        perf_exp     = 64'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        chk("perf_saturate", perf_stall_cnt_o, 32'hFFFF_FFFF);
        do_reset();
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 12)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
